muldiv_unit: RTL

//  Iterative multiply/divide unit in EX, beside the ALU; consumes func from the decoded R-type word.

---
 rtl/muldiv_unit_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: R-type function codes,
// FSM state encoding and small decode helpers.
package muldiv_unit_pkg;

    // R-type func field codes handled by the unit
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // True for the four iterative operations that occupy the unit
    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    function automatic logic is_div(input logic [5:0] f);
        return (f == FN_DIV) || (f == FN_DIVU);
    endfunction

    // Signed variants work on operand magnitudes and fix the sign at the end
    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath on {acc, q}.
//  mul: shift-add, LSB of q selects whether operand is added; pair shifts right.
//  div: restoring step, pair shifts left, trial subtract of operand, quotient bit into q.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    // Compute both step flavours and select by mode
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        acc_next = acc;
        q_next   = q;
        sum      = {1'b0, acc} + (q[0] ? {1'b0, operand} : '0);
        shifted  = {acc, q[WIDTH-1]};
        // Only used when shifted >= operand, so the result always fits WIDTH bits
        trial    = shifted[WIDTH-1:0] - operand;
        if (div_mode) begin
            if (shifted >= {1'b0, operand}) begin
                acc_next = trial;
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {acc_next, q_next} = {sum, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and direct MTHI/MTLO.
// FSM IDLE -> RUN (WIDTH steps) -> FIX (sign correction, HI/LO write) -> IDLE.
// Optional build macro MULDIV_FAST_MULT_EN: MULT/MULTU skip RUN using a
// single-cycle multiplier; division stays iterative.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc, q, operand;
    logic             div_mode, neg_q, neg_r, dz;
    logic [WIDTH-1:0] step_acc, step_q;
    logic             sign_a, sign_b, issue, fast_mul;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] prod_res;
    logic [WIDTH-1:0] quot_res, rem_res;

    assign sign_a = is_signed_op(func) & op_a[WIDTH-1];
    assign sign_b = is_signed_op(func) & op_b[WIDTH-1];
    assign mag_a  = sign_a ? -op_a : op_a;
    assign mag_b  = sign_b ? -op_b : op_b;
    assign issue  = start && !flush && (state == ST_IDLE) && is_muldiv(func);

`ifdef MULDIV_FAST_MULT_EN
    assign fast_mul = (func == FN_MULT) || (func == FN_MULTU);
`else
    assign fast_mul = 1'b0;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (div_mode),
        .acc      (acc),
        .q        (q),
        .operand  (operand),
        .acc_next (step_acc),
        .q_next   (step_q)
    );

    // Sign-corrected results written to HI/LO in FIX
    always_comb begin
        prod_res = neg_q ? -{acc, q} : {acc, q};
        quot_res = dz ? '1 : (neg_q ? -q : q);
        rem_res  = neg_r ? -acc : acc;
    end

    // Next-state decode; flush always returns to IDLE
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (issue) state_next = fast_mul ? ST_FIX : ST_RUN;
            ST_RUN:  if (count == CW'(WIDTH - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    // State register and registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
        end
    end

    // Operand capture, iteration, HI/LO write-back and completion pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            acc      <= '0;
            q        <= '0;
            operand  <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: if (start && !flush) begin
                    if (func == FN_MTHI) hi <= op_a;
                    if (func == FN_MTLO) lo <= op_a;
                    if (is_muldiv(func)) begin
                        count    <= '0;
                        div_mode <= is_div(func);
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        dz       <= is_div(func) && (op_b == '0);
                        acc      <= '0;
                        // Divider shifts the dividend out of q; multiplier shifts the multiplier out
                        if (is_div(func)) begin
                            q       <= mag_a;
                            operand <= mag_b;
                        end else begin
                            q       <= mag_b;
                            operand <= mag_a;
                        end
`ifdef MULDIV_FAST_MULT_EN
                        if (fast_mul) {acc, q} <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
                    end
                end
                ST_RUN: if (!flush) begin
                    acc   <= step_acc;
                    q     <= step_q;
                    count <= count + CW'(1);
                end
                ST_FIX: if (!flush) begin
                    done     <= 1'b1;
                    div_zero <= dz;
                    if (div_mode) begin
                        hi <= rem_res;
                        lo <= quot_res;
                    end else begin
                        hi <= prod_res[2*WIDTH-1:WIDTH];
                        lo <= prod_res[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
